tl_sensor_cond: RTL and testbench



---
 rtl/tl_sensor_cond_pkg.sv | 10 +
 rtl/tl_sensor_chan.sv | 88 ++++++++
 rtl/tl_sensor_cond.sv | 48 ++++
 tb/tb_tl_sensor_cond.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_sensor_cond_pkg.sv
// tl_pkg: shared state encoding and default timing for the sensor conditioning slice.
package tl_pkg;
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_QUAL   = 2'b01;
    localparam logic [1:0] ST_ACTIVE = 2'b10;
    localparam logic [1:0] ST_HOLD   = 2'b11;
    localparam int DEB_CYCLES_DEF   = 4;
    localparam int HOLD_CYCLES_DEF  = 8;
    localparam int STUCK_CYCLES_DEF = 1024;
endpackage

// File: rtl/tl_sensor_chan.sv
// tl_sensor_chan: one detector channel (sync, debounce, release hold-off).
// Stuck-sensor detection is built only with TL_SENSOR_STUCK_DET_EN defined.
module tl_sensor_chan
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
`ifdef TL_SENSOR_STUCK_DET_EN
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF,
`endif
    parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic t,
    output logic fault
);
    localparam int MAXC = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic          s1, s2;
    logic [1:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Transitions happen at terminal count, so cnt never wraps.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                state_nx = s2 ? ST_QUAL : ST_IDLE;
                cnt_nx   = s2 ? CW'(1) : '0;
            end
            ST_QUAL: begin
                state_nx = !s2 ? ST_IDLE : (cnt == CW'(DEB_CYCLES - 1)) ? ST_ACTIVE : ST_QUAL;
                cnt_nx   = (state_nx == ST_QUAL) ? cnt + CW'(1) : '0;
            end
            ST_ACTIVE: begin
                state_nx = s2 ? ST_ACTIVE : ST_HOLD;
                cnt_nx   = s2 ? '0 : CW'(1);
            end
            default: begin
                state_nx = s2 ? ST_ACTIVE : (cnt == CW'(HOLD_CYCLES - 1)) ? ST_IDLE : ST_HOLD;
                cnt_nx   = (state_nx == ST_HOLD) ? cnt + CW'(1) : '0;
            end
        endcase
    end

`ifdef TL_SENSOR_STUCK_DET_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);

    logic [SW-1:0] stk, stk_nx;
    logic          fault_q;

    always_comb stk_nx = !s2 ? '0 : (stk == SW'(STUCK_CYCLES)) ? stk : stk + SW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stk     <= '0;
            fault_q <= 1'b0;
        end else begin
            stk     <= stk_nx;
            fault_q <= fault_q | (stk_nx == SW'(STUCK_CYCLES));
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // A stuck detector must not starve the other street, so fault masks T.
    always_comb t = state[1] & ~fault;
endmodule

// File: rtl/tl_sensor_cond.sv
// tl_sensor_cond: conditions raw street A/B detectors into Ta/Tb for the controller.
// Optional stuck-sensor flags are enabled by TL_SENSOR_STUCK_DET_EN.
module tl_sensor_cond
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
`ifdef TL_SENSOR_STUCK_DET_EN
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF,
`endif
    parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_a,
    input  logic raw_b,
    output logic Ta,
    output logic Tb,
    output logic fault_a,
    output logic fault_b
);
    tl_sensor_chan #(
        .DEB_CYCLES  (DEB_CYCLES),
`ifdef TL_SENSOR_STUCK_DET_EN
        .STUCK_CYCLES(STUCK_CYCLES),
`endif
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_chan_a (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (raw_a),
        .t      (Ta),
        .fault  (fault_a)
    );

    tl_sensor_chan #(
        .DEB_CYCLES  (DEB_CYCLES),
`ifdef TL_SENSOR_STUCK_DET_EN
        .STUCK_CYCLES(STUCK_CYCLES),
`endif
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_chan_b (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (raw_b),
        .t      (Tb),
        .fault  (fault_b)
    );
endmodule

// File: tb/tb_tl_sensor_cond.sv
// tb_tl_sensor_cond: run-length reference model vs. tl_sensor_cond (DEB=4, HOLD=8).
module tb_tl_sensor_cond;
    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int STUCK = 1024;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic raw_a = 1'b0;
    logic raw_b = 1'b0;
    logic Ta, Tb, fault_a, fault_b;

    int pass_cnt = 0;
    int total = 0;

    // Model: a detector is present once its synchronized input has been high
    // for DEB samples in a row, absent once low for HOLD samples in a row.
    bit p1[2], p2[2], mt[2], mf[2];
    int hr[2], lr[2];

    tl_sensor_cond dut (
        .clk    (clk),
        .reset_n(reset_n),
        .raw_a  (raw_a),
        .raw_b  (raw_b),
        .Ta     (Ta),
        .Tb     (Tb),
        .fault_a(fault_a),
        .fault_b(fault_b)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            p1[i] = 0; p2[i] = 0; mt[i] = 0; mf[i] = 0; hr[i] = 0; lr[i] = 0;
        end
    endtask

    function automatic logic [3:0] expv();
        return {mt[0] & ~mf[0], mt[1] & ~mf[1], mf[0], mf[1]};
    endfunction

    task automatic tick(input bit a, input bit b);
        @(negedge clk);
        raw_a = a;
        raw_b = b;
        @(posedge clk);
        if (!reset_n) model_clear();
        else begin
            for (int i = 0; i < 2; i++) begin
                if (p2[i]) begin hr[i]++; lr[i] = 0; end
                else begin hr[i] = 0; lr[i]++; end
                if (!mt[i] && hr[i] >= DEB) mt[i] = 1;
                else if (mt[i] && lr[i] >= HOLD) mt[i] = 0;
`ifdef TL_SENSOR_STUCK_DET_EN
                if (hr[i] >= STUCK) mf[i] = 1;
`endif
                p2[i] = p1[i];
            end
            p1[0] = a;
            p1[1] = b;
        end
        #1;
    endtask

    task automatic do_reset(input bit a, input bit b);
        reset_n = 0;
        #1 model_clear();
        tick(a, b);
        tick(a, b);
        reset_n = 1;
    endtask

    task automatic test_reset();
        int rise_at = -1;
        reset_n = 0;
        raw_a = 1;
        raw_b = 1;
        #1 model_clear();
        for (int k = 0; k < 3; k++) begin
            tick(1, 1);
            total++;
            if ({Ta, Tb, fault_a, fault_b} !== 4'b0000)
                $display("FAIL reset_hold: got %b exp 0000", {Ta, Tb, fault_a, fault_b});
            else pass_cnt++;
        end
        reset_n = 1;
        for (int k = 1; k <= 10; k++) begin
            tick(1, 1);
            total++;
            if ({Ta, Tb, fault_a, fault_b} !== expv())
                $display("FAIL rise_model k=%0d: got %b exp %b", k, {Ta, Tb, fault_a, fault_b}, expv());
            else pass_cnt++;
            if (Ta === 1'b1 && rise_at < 0) rise_at = k;
        end
        total++;
        if (rise_at !== DEB + 2) $display("FAIL rise_latency: got %0d exp %0d", rise_at, DEB + 2);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        bit seen = 0;
        do_reset(0, 0);
        for (int k = 0; k < 14; k++) begin
            tick(k < 3, 0);
            if (Ta === 1'b1) seen = 1;
            total++;
            if ({Ta, Tb, fault_a, fault_b} !== expv())
                $display("FAIL glitch_model k=%0d: got %b exp %b", k, {Ta, Tb, fault_a, fault_b}, expv());
            else pass_cnt++;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL glitch_pulse: got Ta pulse %b exp 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_hold_gap();
        bit dropped = 0;
        int fall_at = -1;
        do_reset(0, 0);
        for (int k = 0; k < 8; k++) tick(1, 0);
        for (int k = 0; k < 9; k++) begin
            tick(k >= 5, 0);
            if (Ta !== 1'b1) dropped = 1;
            total++;
            if ({Ta, Tb, fault_a, fault_b} !== expv())
                $display("FAIL gap_model k=%0d: got %b exp %b", k, {Ta, Tb, fault_a, fault_b}, expv());
            else pass_cnt++;
        end
        total++;
        if (dropped !== 1'b0) $display("FAIL gap_absorb: got drop %b exp 0", dropped);
        else pass_cnt++;
        for (int k = 1; k <= 14; k++) begin
            tick(0, 0);
            if (Ta === 1'b0 && fall_at < 0) fall_at = k;
            total++;
            if ({Ta, Tb, fault_a, fault_b} !== expv())
                $display("FAIL fall_model k=%0d: got %b exp %b", k, {Ta, Tb, fault_a, fault_b}, expv());
            else pass_cnt++;
        end
        total++;
        if (fall_at !== HOLD + 2) $display("FAIL fall_latency: got %0d exp %0d", fall_at, HOLD + 2);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        do_reset(0, 0);
        for (int k = 0; k < 8; k++) begin
            tick(1, 1);
            total++;
            if (Ta !== Tb || {Ta, Tb, fault_a, fault_b} !== expv())
                $display("FAIL simul_rise k=%0d: got %b exp %b", k, {Ta, Tb, fault_a, fault_b}, expv());
            else pass_cnt++;
        end
        for (int k = 0; k < 16; k++) begin
            tick(0, k < 3);
            total++;
            if ({Ta, Tb, fault_a, fault_b} !== expv())
                $display("FAIL simul_fall k=%0d: got %b exp %b", k, {Ta, Tb, fault_a, fault_b}, expv());
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        do_reset(0, 0);
        for (int k = 0; k < 8; k++) tick(1, 0);
        while (!(mt[0] && lr[0] == 5) && guard < 20) begin
            tick(0, 0);
            guard++;
        end
        total++;
        if (Ta !== 1'b1 || guard >= 20) $display("FAIL async_setup: got Ta %b exp 1 in hold", Ta);
        else pass_cnt++;
        #2 reset_n = 0;
        #1;
        total++;
        if (Ta !== 1'b0) $display("FAIL async_reset: got Ta %b exp 0 without clk edge", Ta);
        else pass_cnt++;
        model_clear();
        tick(0, 0);
        reset_n = 1;
        for (int k = 0; k < 12; k++) begin
            tick(0, 0);
            total++;
            if (Ta !== 1'b0 || {Ta, Tb, fault_a, fault_b} !== expv())
                $display("FAIL async_after k=%0d: got %b exp %b", k, {Ta, Tb, fault_a, fault_b}, expv());
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        bit v[2];
        int run[2];
        do_reset(0, 0);
        v[0] = 0; v[1] = 0; run[0] = 0; run[1] = 0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (run[i] == 0) begin
                    v[i] = ~v[i];
                    run[i] = $urandom_range(1, 14);
                end
                run[i]--;
            end
            tick(v[0], v[1]);
            total++;
            if ({Ta, Tb, fault_a, fault_b} !== expv())
                $display("FAIL random k=%0d: got %b exp %b", k, {Ta, Tb, fault_a, fault_b}, expv());
            else pass_cnt++;
        end
    endtask

    task automatic test_stuck();
        int flag_at = -1;
        int exp_at;
`ifdef TL_SENSOR_STUCK_DET_EN
        exp_at = STUCK + 2;
`else
        exp_at = -1;
`endif
        do_reset(0, 1);
        for (int k = 1; k <= STUCK + 6; k++) begin
            tick(0, 1);
            if (fault_b === 1'b1 && flag_at < 0) flag_at = k;
            total++;
            if ({Ta, Tb, fault_a, fault_b} !== expv())
                $display("FAIL stuck_model k=%0d: got %b exp %b", k, {Ta, Tb, fault_a, fault_b}, expv());
            else pass_cnt++;
        end
        total++;
        if (flag_at !== exp_at) $display("FAIL stuck_latency: got %0d exp %0d", flag_at, exp_at);
        else pass_cnt++;
        for (int k = 0; k < 12; k++) begin
            tick(0, 0);
            total++;
            if ({Ta, Tb, fault_a, fault_b} !== expv())
                $display("FAIL stuck_sticky k=%0d: got %b exp %b", k, {Ta, Tb, fault_a, fault_b}, expv());
            else pass_cnt++;
        end
        do_reset(0, 0);
        total++;
        if ({fault_a, fault_b} !== 2'b00) $display("FAIL stuck_clear: got %b exp 00", {fault_a, fault_b});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_hold_gap();
        test_simultaneous();
        test_async_reset();
        test_random();
        test_stuck();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
